// File: rtl/i2c_slave_responder.sv
// I2C target-side responder: oversampled SCL/SDA, START/STOP detection, 7-bit address
// match with ACK, byte reception on RxData/RxValid and byte transmission from TxData.
`timescale 1ns/1ps
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [7:0] TxData,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       TxNext,
    output logic       Addressed,
    output logic       ReadMode
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ADDR      = 3'd1;
    localparam logic [2:0] ADDR_ACK  = 3'd2;
    localparam logic [2:0] WRITE     = 3'd3;
    localparam logic [2:0] WRITE_ACK = 3'd4;
    localparam logic [2:0] READ      = 3'd5;
    localparam logic [2:0] READ_ACK  = 3'd6;
    localparam logic [2:0] WAIT      = 3'd7;

    logic [2:0] state;
    logic       sclS1, sclS2, sclPrev;
    logic       sdaS1, sdaS2, sdaPrev;
    logic [6:0] shiftReg;
    logic [7:0] shiftNext;
    logic [7:0] txShift;
    logic [3:0] bitCnt;
    logic       ackHeld;
    logic       sdaLow;
    logic       sclRise, sclFall, startDet, stopDet;

    assign SDA = sdaLow ? 1'b0 : 1'bz;

    assign sclRise   = sclS2 & ~sclPrev;
    assign sclFall   = ~sclS2 & sclPrev;
    assign startDet  = sclS2 & sclPrev & sdaPrev & ~sdaS2;
    assign stopDet   = sclS2 & sclPrev & ~sdaPrev & sdaS2;
    assign shiftNext = {shiftReg, sdaS2};

    assign Addressed = (state == ADDR_ACK) || (state == WRITE) || (state == WRITE_ACK) ||
                       (state == READ) || (state == READ_ACK);

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            sclS1    <= 1'b1;
            sclS2    <= 1'b1;
            sclPrev  <= 1'b1;
            sdaS1    <= 1'b1;
            sdaS2    <= 1'b1;
            sdaPrev  <= 1'b1;
            shiftReg <= '0;
            txShift  <= '0;
            bitCnt   <= '0;
            ackHeld  <= 1'b0;
            sdaLow   <= 1'b0;
            RxData   <= '0;
            RxValid  <= 1'b0;
            TxNext   <= 1'b0;
            ReadMode <= 1'b0;
        end else begin
            sclS1   <= SCL;
            sclS2   <= sclS1;
            sclPrev <= sclS2;
            sdaS1   <= SDA;
            sdaS2   <= sdaS1;
            sdaPrev <= sdaS2;
            RxValid <= 1'b0;
            TxNext  <= 1'b0;

            if (startDet) begin
                state   <= ADDR;
                bitCnt  <= '0;
                sdaLow  <= 1'b0;
                ackHeld <= 1'b0;
            end else if (stopDet) begin
                state   <= IDLE;
                bitCnt  <= '0;
                sdaLow  <= 1'b0;
                ackHeld <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (sclRise) begin
                        shiftReg <= shiftNext[6:0];
                        if (bitCnt == 4'd7) begin
                            bitCnt <= '0;
                            if (shiftNext[7:1] == SLAVE_ADDR) begin
                                state    <= ADDR_ACK;
                                ReadMode <= shiftNext[0];
                                ackHeld  <= 1'b0;
                            end else begin
                                state <= WAIT;
                            end
                        end else begin
                            bitCnt <= bitCnt + 4'd1;
                        end
                    end
                    // first fall asserts the ACK, second fall ends it and starts the data phase
                    ADDR_ACK: if (sclFall) begin
                        if (!ackHeld) begin
                            sdaLow  <= 1'b1;
                            ackHeld <= 1'b1;
                        end else begin
                            ackHeld <= 1'b0;
                            if (ReadMode) begin
                                txShift <= {TxData[6:0], 1'b0};
                                TxNext  <= 1'b1;
                                sdaLow  <= ~TxData[7];
                                bitCnt  <= 4'd1;
                                state   <= READ;
                            end else begin
                                sdaLow <= 1'b0;
                                bitCnt <= '0;
                                state  <= WRITE;
                            end
                        end
                    end
                    WRITE: if (sclRise) begin
                        shiftReg <= shiftNext[6:0];
                        if (bitCnt == 4'd7) begin
                            RxData  <= shiftNext;
                            RxValid <= 1'b1;
                            bitCnt  <= '0;
                            ackHeld <= 1'b0;
                            state   <= WRITE_ACK;
                        end else begin
                            bitCnt <= bitCnt + 4'd1;
                        end
                    end
                    WRITE_ACK: if (sclFall) begin
                        if (!ackHeld) begin
                            sdaLow  <= 1'b1;
                            ackHeld <= 1'b1;
                        end else begin
                            sdaLow  <= 1'b0;
                            ackHeld <= 1'b0;
                            bitCnt  <= '0;
                            state   <= WRITE;
                        end
                    end
                    // bitCnt counts bits already placed on SDA; the MSB went out on entry
                    READ: if (sclFall) begin
                        if (bitCnt == 4'd8) begin
                            sdaLow <= 1'b0;
                            bitCnt <= '0;
                            state  <= READ_ACK;
                        end else begin
                            sdaLow  <= ~txShift[7];
                            txShift <= {txShift[6:0], 1'b0};
                            bitCnt  <= bitCnt + 4'd1;
                        end
                    end
                    READ_ACK: begin
                        if (sclRise && sdaS2) begin
                            state <= WAIT;
                        end else if (sclFall) begin
                            txShift <= {TxData[6:0], 1'b0};
                            TxNext  <= 1'b1;
                            sdaLow  <= ~TxData[7];
                            bitCnt  <= 4'd1;
                            state   <= READ;
                        end
                    end
                    default: begin
                        sdaLow <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Self-checking bench for i2c_slave_responder: a bit-banged bus master drives SCL/SDA,
// expected received bytes and read bits are queued and compared as the DUT produces them.
`timescale 1ns/1ps
module tb_i2c_slave_responder;

    logic       clock = 1'b0;
    logic       Reset = 1'b1;
    logic       sclM = 1'b1;
    logic       masterLow = 1'b0;
    logic [7:0] TxData = 8'h00;
    logic [7:0] RxData;
    logic       RxValid, TxNext, Addressed, ReadMode;
    wire        sdaBus;

    pullup (sdaBus);
    assign sdaBus = masterLow ? 1'b0 : 1'bz;

    i2c_slave_responder #(.SLAVE_ADDR(7'h42)) dut (
        .clock(clock),
        .Reset(Reset),
        .SCL(sclM),
        .SDA(sdaBus),
        .TxData(TxData),
        .RxData(RxData),
        .RxValid(RxValid),
        .TxNext(TxNext),
        .Addressed(Addressed),
        .ReadMode(ReadMode)
    );

    always #5 clock = ~clock;

    int compared = 0;
    int mismatched = 0;
    int rxCount = 0;
    int txNextCount = 0;
    int slaveLowCnt = 0;
    logic [7:0] expRx[$];
    logic       expBits[$];

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RxValid scoreboard plus pulse / bus-activity counters
    always @(negedge clock) begin
        if (RxValid) begin
            rxCount++;
            if (expRx.size() == 0) checkVal("rxUnexpected", 32'd1, 32'd0);
            else checkVal("rxData", {24'd0, RxData}, {24'd0, expRx.pop_front()});
        end
        if (TxNext) txNextCount++;
        if (!masterLow && sdaBus == 1'b0) slaveLowCnt++;
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic bitSlot(input logic drive, output logic sampled);
        masterLow = ~drive;
        waitClk(4);
        sclM = 1'b1;
        waitClk(4);
        sampled = sdaBus;
        waitClk(4);
        sclM = 1'b0;
        waitClk(4);
    endtask

    task automatic startCond();
        masterLow = 1'b0;
        waitClk(4);
        sclM = 1'b1;
        waitClk(8);
        masterLow = 1'b1;
        waitClk(8);
        sclM = 1'b0;
        waitClk(4);
    endtask

    task automatic stopCond();
        masterLow = 1'b1;
        waitClk(4);
        sclM = 1'b1;
        waitClk(8);
        masterLow = 1'b0;
        waitClk(8);
    endtask

    task automatic writeByte(input logic [7:0] b, input logic expAck, input string tag);
        logic s;
        for (int i = 0; i < 8; i++) bitSlot(b[7-i], s);
        bitSlot(1'b1, s);
        checkVal(tag, {31'd0, s}, {31'd0, expAck});
    endtask

    task automatic readByte(input logic [7:0] exp, input logic masterAck, input logic [7:0] nextTx);
        logic s;
        for (int i = 0; i < 8; i++) expBits.push_back(exp[7-i]);
        for (int i = 0; i < 8; i++) begin
            bitSlot(1'b1, s);
            checkVal("rdBit", {31'd0, s}, {31'd0, expBits.pop_front()});
        end
        TxData = nextTx;
        bitSlot(~masterAck, s);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        int txBase;
        logic s;

        waitClk(3);
        checkVal("rstSda", {31'd0, sdaBus}, 32'd1);
        checkVal("rstRxData", {24'd0, RxData}, 32'd0);
        checkVal("rstRxValid", {31'd0, RxValid}, 32'd0);
        checkVal("rstTxNext", {31'd0, TxNext}, 32'd0);
        checkVal("rstAddressed", {31'd0, Addressed}, 32'd0);
        checkVal("rstReadMode", {31'd0, ReadMode}, 32'd0);
        Reset = 1'b0;
        waitClk(4);

        // write 0x42 <- 0xCA
        startCond();
        writeByte(8'h84, 1'b0, "t1AddrAck");
        checkVal("t1Addressed", {31'd0, Addressed}, 32'd1);
        checkVal("t1ReadMode", {31'd0, ReadMode}, 32'd0);
        expRx.push_back(8'hCA);
        writeByte(8'hCA, 1'b0, "t1DataAck");
        stopCond();
        waitClk(4);
        checkVal("t1AddrAfterStop", {31'd0, Addressed}, 32'd0);
        checkVal("t1RxCount", rxCount, 32'd1);

        // address mismatch 0x43
        base = slaveLowCnt;
        startCond();
        writeByte(8'h86, 1'b1, "t2AddrNack");
        checkVal("t2Addressed", {31'd0, Addressed}, 32'd0);
        writeByte(8'h55, 1'b1, "t2DataNack");
        stopCond();
        waitClk(4);
        checkVal("t2SlaveLow", slaveLowCnt - base, 32'd0);
        checkVal("t2RxCount", rxCount, 32'd1);

        // read 0xA5 (ACK) then 0x3C (NACK)
        TxData = 8'hA5;
        txBase = txNextCount;
        startCond();
        writeByte(8'h85, 1'b0, "t3AddrAck");
        checkVal("t3ReadMode", {31'd0, ReadMode}, 32'd1);
        readByte(8'hA5, 1'b1, 8'h3C);
        checkVal("t3AddressedMid", {31'd0, Addressed}, 32'd1);
        readByte(8'h3C, 1'b0, 8'h00);
        checkVal("t3AddrAfterNack", {31'd0, Addressed}, 32'd0);
        checkVal("t3TxNextCount", txNextCount - txBase, 32'd2);
        base = slaveLowCnt;
        bitSlot(1'b1, s);
        checkVal("t3WaitSilent", slaveLowCnt - base, 32'd0);
        stopCond();

        // write 0x11, repeated START, read 0x77
        startCond();
        writeByte(8'h84, 1'b0, "t4AddrAck");
        expRx.push_back(8'h11);
        writeByte(8'h11, 1'b0, "t4DataAck");
        checkVal("t4ReadModeW", {31'd0, ReadMode}, 32'd0);
        TxData = 8'h77;
        startCond();
        checkVal("t4AddrAfterRs", {31'd0, Addressed}, 32'd0);
        writeByte(8'h85, 1'b0, "t4RdAddrAck");
        checkVal("t4ReadModeR", {31'd0, ReadMode}, 32'd1);
        readByte(8'h77, 1'b0, 8'h00);
        stopCond();
        waitClk(4);
        checkVal("t4RxCount", rxCount, 32'd2);

        // STOP in the middle of a write byte
        startCond();
        writeByte(8'h84, 1'b0, "t5AddrAck");
        bitSlot(1'b1, s);
        bitSlot(1'b0, s);
        bitSlot(1'b1, s);
        bitSlot(1'b1, s);
        stopCond();
        waitClk(4);
        checkVal("t5AddrAfterStop", {31'd0, Addressed}, 32'd0);
        checkVal("t5RxCountAbort", rxCount, 32'd2);
        checkVal("t5SdaReleased", {31'd0, sdaBus}, 32'd1);
        startCond();
        writeByte(8'h84, 1'b0, "t5AddrAck2");
        expRx.push_back(8'h80);
        writeByte(8'h80, 1'b0, "t5DataAck");
        stopCond();
        waitClk(4);
        checkVal("t5RxCount", rxCount, 32'd3);

        // reset while a 0 read bit is on the bus
        TxData = 8'h5A;
        startCond();
        writeByte(8'h85, 1'b0, "t6AddrAck");
        masterLow = 1'b0;
        waitClk(1);
        checkVal("t6BitLow", {31'd0, sdaBus}, 32'd0);
        #2 Reset = 1'b1;
        #1 checkVal("t6SdaRelease", {31'd0, sdaBus}, 32'd1);
        checkVal("t6Addressed", {31'd0, Addressed}, 32'd0);
        checkVal("t6ReadMode", {31'd0, ReadMode}, 32'd0);
        checkVal("t6RxData", {24'd0, RxData}, 32'd0);
        checkVal("t6TxNext", {31'd0, TxNext}, 32'd0);
        waitClk(2);
        Reset = 1'b0;
        waitClk(2);
        base = slaveLowCnt;
        txBase = txNextCount;
        for (int i = 0; i < 9; i++) bitSlot(1'b1, s);
        checkVal("t6NoResponse", slaveLowCnt - base, 32'd0);
        checkVal("t6NoTxNext", txNextCount - txBase, 32'd0);
        checkVal("t6AddressedIdle", {31'd0, Addressed}, 32'd0);
        stopCond();
        startCond();
        writeByte(8'h84, 1'b0, "t6AddrAck2");
        expRx.push_back(8'h33);
        writeByte(8'h33, 1'b0, "t6DataAck");
        stopCond();
        waitClk(4);
        checkVal("rxQueueDrained", expRx.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
